// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative multiply/divide unit owning the HI/LO registers.
// Multiplies complete after MUL_LAT busy cycles. Divides use a 32-step
// restoring loop followed by one sign-fix cycle.
// Optional macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 8-11).
module hilo_muldiv_unit #(
  parameter int MUL_LAT = 4,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            hilo_read,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t          state, state_nx;
  logic [4:0]      cnt;
  logic [XLEN-1:0] opa;    // mul operand A / dividend shifting into quotient
  logic [XLEN-1:0] opb;    // mul operand B / divisor magnitude
  logic [XLEN-1:0] rem;    // partial remainder, always < divisor
  logic            msign, rsign, qneg, div0;
  logic            accept;
  logic            dec_mul, dec_div, dec_sgn, dec_mthi, dec_mtlo;
  logic [32:0]     r_sh, diff;
  logic [63:0]     pa, pb, prod, mul_res;
`ifdef MDU_MADD_EN
  logic            dec_acc, dec_sub, acc_en, acc_sub;
`endif

  assign busy   = (state != S_IDLE);
  assign stall  = busy & (start | hilo_read);
  assign accept = start & ~busy & ~flush;

  // Opcode decode; unknown codes fall through as NOP.
  always_comb begin
    dec_mul  = (op == 4'd1) || (op == 4'd2);
    dec_div  = (op == 4'd3) || (op == 4'd4);
    dec_sgn  = (op == 4'd1) || (op == 4'd3);
    dec_mthi = (op == 4'd5);
    dec_mtlo = (op == 4'd6);
`ifdef MDU_MADD_EN
    dec_acc  = (op >= 4'd8) && (op <= 4'd11);
    dec_sub  = (op == 4'd10) || (op == 4'd11);
    dec_mul  = dec_mul | dec_acc;
    dec_sgn  = dec_sgn | (op == 4'd8) | (op == 4'd10);
`endif
  end

  // Multiplier and one restoring-divide step.
  always_comb begin
    pa   = msign ? {{32{opa[31]}}, opa} : {32'b0, opa};
    pb   = msign ? {{32{opb[31]}}, opb} : {32'b0, opb};
    prod = pa * pb;
`ifdef MDU_MADD_EN
    // Prior {hi,lo} is read at completion, so a flushed accumulate is a no-op.
    mul_res = !acc_en ? prod : (acc_sub ? {hi, lo} - prod : {hi, lo} + prod);
`else
    mul_res = prod;
`endif
    r_sh = {rem, opa[31]};
    diff = r_sh - {1'b0, opb};
  end

  // Next-state: flush always wins over everything except reset.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept && dec_mul)      state_nx = S_MUL;
              else if (accept && dec_div) state_nx = S_DIV;
      S_MUL:  if (cnt == 5'd0) state_nx = S_IDLE;
      S_DIV:  if (cnt == 5'd0) state_nx = S_FIX;
      S_FIX:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Operand latching, iteration, and HI/LO writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      opa   <= '0;
      opb   <= '0;
      rem   <= '0;
      cnt   <= '0;
      msign <= 1'b0;
      rsign <= 1'b0;
      qneg  <= 1'b0;
      div0  <= 1'b0;
`ifdef MDU_MADD_EN
      acc_en  <= 1'b0;
      acc_sub <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          if (dec_mthi) hi <= rs_val;
          if (dec_mtlo) lo <= rs_val;
          if (dec_mul) begin
            opa   <= rs_val;
            opb   <= rt_val;
            msign <= dec_sgn;
            cnt   <= 5'(MUL_LAT - 1);
`ifdef MDU_MADD_EN
            acc_en  <= dec_acc;
            acc_sub <= dec_sub;
`endif
          end
          if (dec_div) begin
            // Divide on magnitudes; signs are reapplied in the fix cycle.
            opa   <= (dec_sgn && rs_val[31]) ? -rs_val : rs_val;
            opb   <= (dec_sgn && rt_val[31]) ? -rt_val : rt_val;
            rsign <= dec_sgn & rs_val[31];
            qneg  <= dec_sgn & (rs_val[31] ^ rt_val[31]);
            div0  <= (rt_val == '0);
            rem   <= '0;
            cnt   <= 5'd31;
          end
        end
        S_MUL: if (!flush) begin
          if (cnt == 5'd0) {hi, lo} <= mul_res;
          else             cnt <= cnt - 5'd1;
        end
        S_DIV: if (!flush) begin
          opa <= {opa[30:0], ~diff[32]};
          rem <= diff[32] ? r_sh[31:0] : diff[31:0];
          cnt <= cnt - 5'd1;
        end
        S_FIX: if (!flush) begin
          // Divide by zero leaves rem = |rs|, so hi restores to rs_val.
          lo <= div0 ? '1 : (qneg ? -opa : opa);
          hi <= rsign ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit; results are queued on issue
// and compared against {hi,lo} once busy falls.
module tb_hilo_muldiv_unit;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst, start, hilo_read, flush;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];

  hilo_muldiv_unit #(.MUL_LAT(MUL_LAT), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .hilo_read(hilo_read), .flush(flush), .busy(busy),
    .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Present one op for a single edge, return at the following negedge.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk); start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk); start = 1'b0; op = 4'd0;
  endtask

  // Count negedges with busy high, bounded.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin cyc++; @(negedge clk); end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; op = 4'd5; rs_val = 32'hFFFF_FFFF; rt_val = '0;
    hilo_read = 1'b0; flush = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 4'd0;
  endtask

  task automatic test_mult;
    logic [3:0]  ops [3] = '{4'd1, 4'd2, 4'd1};
    logic [31:0] as  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [63:0] res [3] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFE_0000_0001,
                             64'h4000_0000_0000_0000};
    int cyc; logic [63:0] exv;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i]);
      exp_q.push_back(res[i]);
      wait_idle(cyc);
      n_checks++; if (cyc !== MUL_LAT) begin n_fail++; $display("FAIL mult_lat[%0d]: got %0d want %0d", i, cyc, MUL_LAT); end
      exv = exp_q.pop_front();
      n_checks++; if ({hi, lo} !== exv) begin n_fail++; $display("FAIL mult_res[%0d]: got %h want %h", i, {hi, lo}, exv); end
    end
  endtask

  task automatic test_div;
    logic [3:0]  ops [7] = '{4'd4, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    logic [31:0] as  [7] = '{32'd100, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000,
                             32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    logic [31:0] bs  [7] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF,
                             32'hFFFF_FFFE, 32'd0, 32'h10};
    logic [63:0] res [7] = '{64'h0000_0002_0000_000E, 64'hFFFF_FFFF_FFFF_FFFD,
                             64'h0000_0005_FFFF_FFFF, 64'h0000_0000_8000_0000,
                             64'h0000_0001_FFFF_FFFD, 64'hFFFF_FFF9_FFFF_FFFF,
                             64'h0000_000F_0FFF_FFFF};
    int cyc; logic [63:0] exv;
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], as[i], bs[i]);
      exp_q.push_back(res[i]);
      wait_idle(cyc);
      n_checks++; if (cyc !== DIV_LAT) begin n_fail++; $display("FAIL div_lat[%0d]: got %0d want %0d", i, cyc, DIV_LAT); end
      exv = exp_q.pop_front();
      n_checks++; if ({hi, lo} !== exv) begin n_fail++; $display("FAIL div_res[%0d]: got %h want %h", i, {hi, lo}, exv); end
    end
  endtask

  task automatic test_mthi_mtlo;
    int cyc; logic [63:0] exv;
    @(negedge clk); start = 1'b1; op = 4'd5; rs_val = 32'h1234_5678;
    @(negedge clk); op = 4'd6; rs_val = 32'h9ABC_DEF0;
    n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi: got %h want 12345678", hi); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b want 0", busy); end
    @(negedge clk); start = 1'b0; op = 4'd0;
    n_checks++; if (lo !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL mtlo: got %h want 9abcdef0", lo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy: got %b want 0", busy); end
    // MTHI held by the pipeline behind a MULT.
    issue(4'd1, 32'd3, 32'd5);
    exp_q.push_back(64'h0000_0000_0000_000F);
    start = 1'b1; op = 4'd5; rs_val = 32'hCAFE_BABE;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mthi_stall: got %b want 1", stall); end
    cyc = 0;
    while (busy && cyc < 50) begin @(negedge clk); cyc++; end
    exv = exp_q.pop_front();
    n_checks++; if ({hi, lo} !== exv) begin n_fail++; $display("FAIL mthi_held: got %h want %h", {hi, lo}, exv); end
    @(negedge clk); start = 1'b0; op = 4'd0;
    n_checks++; if ({hi, lo} !== 64'hCAFE_BABE_0000_000F) begin n_fail++; $display("FAIL mthi_after: got %h want cafebabe0000000f", {hi, lo}); end
  endtask

  task automatic test_stall_flush;
    int cyc, viol; logic [63:0] exv;
    issue(4'd4, 32'd100, 32'd7);
    exp_q.push_back(64'h0000_0002_0000_000E);
    repeat (8) @(negedge clk);
    hilo_read = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL read_stall: got %b want 1", stall); end
    viol = 0; cyc = 0;
    while (busy && cyc < 100) begin if (!stall) viol++; @(negedge clk); cyc++; end
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL read_stall_hold: got %0d gaps want 0", viol); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL read_stall_drop: got %b want 0", stall); end
    hilo_read = 1'b0;
    exv = exp_q.pop_front();
    n_checks++; if ({hi, lo} !== exv) begin n_fail++; $display("FAIL read_res: got %h want %h", {hi, lo}, exv); end
    // Flush mid-divide.
    issue(4'd4, 32'd200, 32'd3);
    repeat (18) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
    n_checks++; if ({hi, lo} !== exv) begin n_fail++; $display("FAIL flush_hilo: got %h want %h", {hi, lo}, exv); end
    repeat (40) @(negedge clk);
    n_checks++; if ({busy, hi, lo} !== {1'b0, exv}) begin n_fail++; $display("FAIL flush_late: got %b/%h want 0/%h", busy, {hi, lo}, exv); end
    // Start coincident with flush is dropped.
    @(negedge clk); flush = 1'b1; start = 1'b1; op = 4'd6; rs_val = 32'hDEAD_BEEF;
    @(negedge clk); flush = 1'b0; start = 1'b0; op = 4'd0;
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL flush_drop: got %h want 0000000e", lo); end
  endtask

  task automatic test_back_to_back;
    int cyc; logic [63:0] exv;
    issue(4'd2, 32'd6, 32'd7);
    exp_q.push_back(64'd42);
    wait_idle(cyc);
    exv = exp_q.pop_front();
    n_checks++; if ({hi, lo} !== exv) begin n_fail++; $display("FAIL b2b_first: got %h want %h", {hi, lo}, exv); end
    start = 1'b1; op = 4'd4; rs_val = 32'd1000; rt_val = 32'd10;
    @(negedge clk); start = 1'b0; op = 4'd0;
    exp_q.push_back(64'd100);
    wait_idle(cyc);
    n_checks++; if (cyc !== DIV_LAT) begin n_fail++; $display("FAIL b2b_lat: got %0d want %0d", cyc, DIV_LAT); end
    exv = exp_q.pop_front();
    n_checks++; if ({hi, lo} !== exv) begin n_fail++; $display("FAIL b2b_second: got %h want %h", {hi, lo}, exv); end
  endtask

  task automatic test_madd;
    int cyc; logic [63:0] exv; logic [63:0] cur;
    logic [3:0] nops [3] = '{4'd7, 4'd12, 4'd15};
`ifdef MDU_MADD_EN
    int lat = MUL_LAT;
    logic [63:0] r1 = 64'd22, r2 = 64'hFFFF_FFFF_FFFF_FFF8;
`else
    int lat = 0;
    logic [63:0] r1 = 64'd10, r2 = 64'd10;
`endif
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'd10, 32'd0);
    issue(4'd9, 32'd3, 32'd4);
    exp_q.push_back(r1);
    wait_idle(cyc);
    n_checks++; if (cyc !== lat) begin n_fail++; $display("FAIL maddu_lat: got %0d want %0d", cyc, lat); end
    exv = exp_q.pop_front();
    n_checks++; if ({hi, lo} !== exv) begin n_fail++; $display("FAIL maddu_res: got %h want %h", {hi, lo}, exv); end
    issue(4'd10, 32'd1, 32'd30);
    exp_q.push_back(r2);
    wait_idle(cyc);
    exv = exp_q.pop_front();
    n_checks++; if ({hi, lo} !== exv) begin n_fail++; $display("FAIL msub_res: got %h want %h", {hi, lo}, exv); end
    cur = r2;
    // A flushed MADD must leave hi/lo alone.
    issue(4'd8, 32'd5, 32'd5);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    repeat (MUL_LAT + 2) @(negedge clk);
    n_checks++; if ({busy, hi, lo} !== {1'b0, cur}) begin n_fail++; $display("FAIL madd_flush: got %b/%h want 0/%h", busy, {hi, lo}, cur); end
    for (int i = 0; i < 3; i++) begin
      issue(nops[i], 32'h5555_AAAA, 32'h1234_0000);
      n_checks++; if ({busy, hi, lo} !== {1'b0, cur}) begin n_fail++; $display("FAIL undef_op[%0d]: got %b/%h want 0/%h", nops[i], busy, {hi, lo}, cur); end
    end
  endtask

  task automatic test_reset_midop;
    issue(4'd3, 32'd99, 32'd9);
    rst = 1'b1; flush = 1'b1;
    @(negedge clk); rst = 1'b0; flush = 1'b0;
    n_checks++; if ({busy, hi, lo} !== 65'd0) begin n_fail++; $display("FAIL reset_midop: got %b/%h want 0/0", busy, {hi, lo}); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_stall_flush();
    test_back_to_back();
    test_madd();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, located in the EX stage of PipelineCPU.
- EX issues MULT/MULTU/DIV/DIVU/MTHI/MTLO. MFHI/MFLO read hi/lo directly.
- While an operation is in flight, `stall` freezes IF/ID/EX when a dependent instruction reaches EX.

Parameters:
- MUL_LAT, 4: cycles busy for a multiply (1..8).
- XLEN, 32: operand width. Only 32 is supported.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  EX-stage instruction is an MDU op this cycle.
- op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 8 MADD, 9 MADDU, 10 MSUB, 11 MSUBU.
- rs_val  in  32  operand A / MTHI-MTLO source.
- rt_val  in  32  operand B.
- hilo_read  in  1  EX-stage instruction is MFHI or MFLO.
- flush  in  1  squash any in-flight op (exception/syscall).
- busy  out  1  operation in flight (registered).
- stall  out  1  combinational: busy & (start | hilo_read).
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset: state IDLE, busy=0, hi=0, lo=0, counters 0. rst overrides flush and start.
- States: IDLE, MUL, DIV, FIX.
- Accept rule: start=1, busy=0, flush=0 at a posedge. A start while busy is ignored; the pipeline holds the instruction via stall, so it re-presents.
- MTHI/MTLO:
  - Accepted: writes hi/lo at that edge. No busy.
  - While busy: stalled, not written.
- MULT/MULTU:
  - Latch operands, go to MUL, busy=1 for exactly MUL_LAT cycles.
  - {hi,lo} <= 64-bit product at the edge that returns to IDLE.
  - MULT is signed×signed; MULTU is unsigned.
- DIV/DIVU:
  - Latch operand magnitudes and signs (signed op only), go to DIV.
  - Restoring divide, 1 quotient bit per cycle, 32 cycles, then FIX for 1 cycle of sign correction. busy=1 for 33 cycles total.
  - lo=quotient, hi=remainder written on the FIX→IDLE edge.
  - Quotient is truncated toward zero. Remainder takes the sign of the dividend.
- Divide by zero (rt_val=0): lo=0xFFFFFFFF, hi=rs_val; same 33-cycle latency.
- Signed overflow: 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Back-to-back: a new start is accepted the cycle busy reads 0. Result of op N is visible on hi/lo before op N+1 starts.
- hilo_read with busy=0: no state change. hi/lo already hold the latest result (no forwarding needed).
- flush:
  - Any state → IDLE next edge, busy=0, hi/lo unchanged.
  - A start in the same cycle as flush is dropped.
- Undefined op codes (7, 12–15), and 8–11 when the feature is off: treated as NOP, no state change, no busy.
- All arithmetic is 32-bit. Products are 64-bit. Intermediate remainder is 33-bit.

Optional Feature:
Macro MDU_MADD_EN.
- Defined:
  - ops 8–11 follow the MUL path: {hi,lo} <= {hi,lo} ± product, same MUL_LAT.
  - Signed for MADD/MSUB, unsigned for MADDU/MSUBU; accumulation is modulo 2^64.
  - The prior {hi,lo} is sampled at completion, so a flushed MADD leaves hi/lo unchanged.
- Undefined: ops 8–11 decode as NOP; no accumulate logic is synthesized.

Test Plan:
- Reset then MULT rs=0xFFFFFFFD (-3), rt=7 → busy high 4 cycles (MUL_LAT=4); then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU 100/7 → busy 33 cycles, lo=14, hi=2. DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 5/0 → lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Start DIVU 100/7, assert hilo_read at cycle 10 → stall=1 until busy drops; flush at cycle 20 of a second DIVU → busy=0 next cycle, hi/lo still 2/14.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → hi/lo updated each next edge, busy stays 0; MTHI during a MULT → stall=1, hi written only after MULT completes.
- With MDU_MADD_EN: hi=0, lo=10, MADDU 3×4 → lo=22, hi=0; MSUB 1×30 → {hi,lo}=0xFFFFFFFF_FFFFFFF8. Without the macro: same ops leave hi/lo unchanged, busy=0.
